// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the PC/fetch unit: next-PC select codes, fetch FSM
// states and architectural constants.
package pc_fetch_unit_pkg;

  typedef enum logic [1:0] {
    SEL_SEQ  = 2'b00,
    SEL_BR   = 2'b01,
    SEL_JALR = 2'b10,
    SEL_JAL  = 2'b11
  } sel_e;

  typedef enum logic [1:0] {
    FETCH = 2'b00,
    WAIT  = 2'b01,
    EXEC  = 2'b10,
    HALT  = 2'b11
  } state_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] INSTR_BYTES      = 32'd4;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection; flags targets that are not word aligned.
module next_pc_calc
  import pc_fetch_unit_pkg::*;
(
  input  logic [31:0] pc,
  input  sel_e        sel,
  input  logic        branch_taken,
  input  logic [31:0] imm,
  input  logic [31:0] rs1_data,
  output logic [31:0] next_pc,
  output logic        misaligned
);

  logic [31:0] seq_pc;
  logic [31:0] rel_pc;
  logic [31:0] jalr_pc;

  // All sums wrap modulo 2^32 by construction of the 32-bit adders.
  assign seq_pc  = pc + INSTR_BYTES;
  assign rel_pc  = pc + imm;
  assign jalr_pc = (rs1_data + imm) & ~32'h1;

  always_comb begin
    // NOTE: default first so every path assigns next_pc and no latch is inferred.
    next_pc = seq_pc;
    case (sel)
      SEL_SEQ:  next_pc = seq_pc;
      SEL_BR:   next_pc = branch_taken ? rel_pc : seq_pc;
      SEL_JALR: next_pc = jalr_pc;
      SEL_JAL:  next_pc = rel_pc;
    endcase
  end

  assign misaligned = |next_pc[1:0];

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and single-outstanding instruction fetch sequencer:
// FETCH issues one request, WAIT collects it, EXEC holds it until commit.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  sel_bit_mux,
  input  logic        branch_taken,
  input  logic [31:0] imm,
  input  logic [31:0] rs1_data,
  input  logic        commit,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        misalign_err
);

  state_e      state;
  logic [31:0] next_pc;
  logic        misaligned;

  next_pc_calc u_next_pc_calc (
    .pc           (pc),
    .sel          (sel_e'(sel_bit_mux)),
    .branch_taken (branch_taken),
    .imm          (imm),
    .rs1_data     (rs1_data),
    .next_pc      (next_pc),
    .misaligned   (misaligned)
  );

  assign imem_addr = pc;
  assign pc_plus4  = pc + INSTR_BYTES;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= FETCH;
      pc           <= RESET_PC;
      instr        <= NOP_INSTR;
      instr_valid  <= 1'b0;
      imem_req     <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          imem_req <= 1'b1;
          state    <= WAIT;
        end
        WAIT: begin
          // The request is a single-cycle pulse; the response may take any time.
          imem_req <= 1'b0;
          if (imem_rvalid) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            state       <= EXEC;
          end
        end
        EXEC: begin
          if (commit) begin
            instr_valid <= 1'b0;
            if (misaligned) begin
              misalign_err <= 1'b1;
              state        <= HALT;
            end else begin
              pc    <= next_pc;
              state <= FETCH;
            end
          end
        end
        HALT: begin
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: acts as instruction memory and control
// unit, predicting outputs from the architectural rules of the fetch unit.
module tb_pc_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic [1:0]  sel_bit_mux;
  logic        branch_taken;
  logic [31:0] imm;
  logic [31:0] rs1_data;
  logic        commit;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        misalign_err;

  pc_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sel_bit_mux  (sel_bit_mux),
    .branch_taken (branch_taken),
    .imm          (imm),
    .rs1_data     (rs1_data),
    .commit       (commit),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .misalign_err (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int req_seen = 0;
  int resp_given = 0;

  // Architectural model state
  logic [31:0] model_pc    = RST_PC;
  logic [31:0] model_instr = NOP;
  logic        model_valid = 1'b0;
  logic        model_err   = 1'b0;
  logic        model_halt  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [1:0] sel,
                                             input logic bt, input logic [31:0] im,
                                             input logic [31:0] rs1);
    case (sel)
      2'd0:    return cur + 32'd4;
      2'd1:    return bt ? cur + im : cur + 32'd4;
      2'd2:    return (rs1 + im) & 32'hFFFF_FFFE;
      default: return cur + im;
    endcase
  endfunction

  // Cycle-by-cycle comparison against the model, mid-cycle
  always @(negedge clk) begin
    if (rst_n) begin
      check("pc", pc, model_pc);
      check("pc_plus4", pc_plus4, model_pc + 32'd4);
      check("imem_addr", imem_addr, model_pc);
      check("instr", instr, model_instr);
      check("instr_valid", {31'd0, instr_valid}, {31'd0, model_valid});
      check("misalign_err", {31'd0, misalign_err}, {31'd0, model_err});
      if (model_halt) check("halt_no_req", {31'd0, imem_req}, 32'd0);
      if (imem_req) begin
        check("one_outstanding", req_seen - resp_given, 0);
        req_seen++;
      end
    end
  end

  task automatic apply_reset();
    @(posedge clk); #1;
    rst_n       = 1'b0;
    model_pc    = RST_PC;
    model_instr = NOP;
    model_valid = 1'b0;
    model_err   = 1'b0;
    model_halt  = 1'b0;
    resp_given  = req_seen;
    #1;
    check("rst_pc", pc, RST_PC);
    check("rst_instr", instr, NOP);
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_err", {31'd0, misalign_err}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Called in the FETCH cycle; the request must appear on the next edge.
  task automatic do_fetch(input logic [31:0] data, input int waits, input bit noise);
    int  base = req_seen;
    int  polls = 0;
    bit  got = 1'b0;
    if (noise) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
    end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      imem_rvalid = 1'b0;
      polls++;
      if (noise && i == 0) check("stale_ignored", instr, model_instr);
      if (imem_req) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      check("req_timeout", 32'd0, 32'd1);
      return;
    end
    check("req_latency", polls, 1);
    check("fetch_addr", imem_addr, model_pc);
    for (int k = 0; k < waits; k++) begin
      if (noise) commit = 1'b1;
      @(posedge clk); #1;
      commit = 1'b0;
    end
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    @(posedge clk); #1;
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    resp_given++;
    model_instr = data;
    model_valid = 1'b1;
    check("reqs_per_fetch", req_seen - base, 1);
  endtask

  task automatic do_commit(input logic [1:0] sel, input logic bt, input logic [31:0] im,
                           input logic [31:0] rs1, input int idle, input bit noise);
    logic [31:0] target;
    for (int k = 0; k < idle; k++) begin
      if (noise) begin
        imem_rvalid = 1'b1;
        imem_rdata  = $urandom;
      end
      @(posedge clk); #1;
      imem_rvalid = 1'b0;
    end
    sel_bit_mux  = sel;
    branch_taken = bt;
    imm          = im;
    rs1_data     = rs1;
    commit       = 1'b1;
    target       = model_next(model_pc, sel, bt, im, rs1);
    @(posedge clk); #1;
    commit       = 1'b0;
    sel_bit_mux  = 2'($urandom);
    branch_taken = 1'($urandom);
    imm          = $urandom;
    rs1_data     = $urandom;
    model_valid  = 1'b0;
    if (target[1:0] != 2'b00) begin
      model_err  = 1'b1;
      model_halt = 1'b1;
    end else begin
      model_pc = target;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [31:0] saved_pc;
    int          saved_reqs;
    logic [1:0]  rsel;
    logic [31:0] rimm;
    logic [31:0] rrs1;

    rst_n = 1'b0; sel_bit_mux = 2'd0; branch_taken = 1'b0; imm = 32'd0;
    rs1_data = 32'd0; commit = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;

    apply_reset();

    // Sequential fetch from reset
    do_fetch(32'h0010_0093, 1, 1'b0);
    do_commit(2'd0, 1'b0, 32'd0, 32'd0, 0, 1'b0);
    check("seq_pc1", pc, 32'h4);
    do_fetch(32'h0020_0113, 1, 1'b0);
    do_commit(2'd0, 1'b0, 32'd0, 32'd0, 1, 1'b0);
    check("seq_pc2", pc, 32'h8);
    do_fetch(32'h0030_0193, 1, 1'b0);
    check("instr_lit", instr, 32'h0030_0193);

    // Branch taken / not taken from 0x100
    do_commit(2'd3, 1'b0, 32'h0000_00F8, 32'd0, 0, 1'b0);
    check("jal_pc", pc, 32'h100);
    do_fetch(32'h1111_1111, 1, 1'b0);
    do_commit(2'd1, 1'b1, 32'hFFFF_FFF0, 32'd0, 0, 1'b0);
    check("br_taken", pc, 32'h0F0);
    do_fetch(32'h2222_2222, 2, 1'b0);
    do_commit(2'd3, 1'b0, 32'h0000_0010, 32'd0, 0, 1'b0);
    check("jal_back", pc, 32'h100);
    do_fetch(32'h3333_3333, 1, 1'b0);
    do_commit(2'd1, 1'b0, 32'hFFFF_FFF0, 32'd0, 0, 1'b0);
    check("br_not_taken", pc, 32'h104);

    // Long wait plus spurious rvalid/commit, then wrap-around
    do_fetch(32'h4444_4444, 4, 1'b1);
    do_commit(2'd3, 1'b0, 32'hFFFF_FEF8, 32'd0, 3, 1'b1);
    check("jal_top", pc, 32'hFFFF_FFFC);
    check("pc_plus4_wrap", pc_plus4, 32'h0);
    do_fetch(32'h5555_5555, 1, 1'b0);
    do_commit(2'd0, 1'b0, 32'd0, 32'd0, 0, 1'b0);
    check("wrap_pc", pc, 32'h0);
    check("wrap_no_err", {31'd0, misalign_err}, 32'd0);

    // JALR with bit0 cleared, aligned result
    do_fetch(32'h6666_6666, 1, 1'b0);
    do_commit(2'd2, 1'b0, 32'h0000_0010, 32'h0000_0301, 0, 1'b0);
    check("jalr_pc", pc, 32'h310);

    // Randomized traffic with aligned targets
    for (int n = 0; n < 150; n++) begin
      do_fetch($urandom, $urandom_range(1, 4), 1'($urandom));
      rsel = 2'($urandom);
      rimm = $urandom & 32'hFFFF_FFFC;
      rrs1 = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(0, 1));
      do_commit(rsel, 1'($urandom), rimm, rrs1, $urandom_range(0, 3), 1'($urandom));
    end

    // Reset while waiting for a response
    do_fetch(32'h7777_7777, 1, 1'b0);
    do_commit(2'd0, 1'b0, 32'd0, 32'd0, 0, 1'b0);
    @(posedge clk); #1;
    check("pre_rst_req", {31'd0, imem_req}, 32'd1);
    apply_reset();
    do_fetch(32'h8888_8888, 2, 1'b1);
    check("post_rst_pc", pc, RST_PC);
    check("post_rst_instr", instr, 32'h8888_8888);

    // Misaligned JALR target halts the unit
    saved_pc = model_pc;
    do_commit(2'd2, 1'b0, 32'd0, 32'h0000_0203, 1, 1'b0);
    check("misalign_pc_held", pc, saved_pc);
    check("misalign_flag", {31'd0, misalign_err}, 32'd1);
    saved_reqs = req_seen;
    for (int k = 0; k < 10; k++) begin
      commit      = 1'b1;
      imem_rvalid = 1'b1;
      imem_rdata  = $urandom;
      @(posedge clk); #1;
    end
    commit      = 1'b0;
    imem_rvalid = 1'b0;
    check("halt_reqs", req_seen - saved_reqs, 0);
    check("halt_valid", {31'd0, instr_valid}, 32'd0);
    check("halt_err_sticky", {31'd0, misalign_err}, 32'd1);

    // Reset releases HALT
    apply_reset();
    do_fetch(32'h9999_9999, 1, 1'b0);
    check("after_halt_pc", pc, RST_PC);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
